// File: rtl/apb_uart_pkg.sv
// Shared register map, bit positions and FSM encodings for the APB UART core.
package apb_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    localparam int ST_TX_EMPTY   = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_RX_EMPTY   = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_RX_OVERRUN = 4;
    localparam int ST_FRAME_ERR  = 5;
    localparam int ST_PARITY_ERR = 6;
    localparam int ST_TX_BUSY    = 7;

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_PAR_EN   = 1;
    localparam int CTRL_PAR_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // Even parity of the character, inverted for odd parity; unused upper bits must be zero.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with show-ahead read data; a pop on empty is ignored.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             pop_ok_s;
    logic             push_ok_s;

    // A full FIFO still accepts a push when the same cycle pops.
    assign pop_ok_s  = pop_i & ~empty_o;
    assign push_ok_s = push_i & (~full_o | pop_ok_s);

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) wr_ptr_q <= wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            count_q <= count_q + {{AW{1'b0}}, push_ok_s} - {{AW{1'b0}}, pop_ok_s};
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_s) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/apb_uart_core.sv
// APB-attached UART: register file, TX/RX FIFOs and the serial TX/RX state machines.
module apb_uart_core
    import apb_uart_pkg::*;
#(
    parameter int          DATA_BITS  = 8,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    input  logic        pwrite,
    input  logic        psel,
    input  logic        penable,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    input  logic        rx,
    output logic        tx
);
    localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    logic                 access_s, pslverr_s, status_rd_s, ctrl_wr_s, div_wr_s;
    logic [31:0]          prdata_s;
    logic [1:0]           reg_s;
    logic [7:0]           status_s, tx_wide_s, rx_wide_s;
    logic [2:0]           ctrl_q;
    logic [15:0]          div_q;
    logic                 ovr_q, frm_q, par_q;
    logic                 tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
    logic                 rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
    logic [DATA_BITS-1:0] tx_rdata_s, rx_rdata_s;
    logic [CW-1:0]        tx_count_s, rx_count_s;
    tx_state_t            tx_state_q;
    logic [15:0]          tx_cnt_q;
    logic [2:0]           tx_idx_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic                 tx_par_q, tx_q;
    rx_state_t            rx_state_q;
    logic [15:0]          rx_cnt_q;
    logic [2:0]           rx_idx_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_par_q, rx_s1_q, rx_s2_q, rx_prev_q;
    logic                 rx_stop_smp_s, par_bad_s, frm_evt_s, par_evt_s, ovr_evt_s;
    logic                 unused_s;

    // Gating with rst keeps the bus outputs quiet while in reset.
    assign access_s = psel & penable & rst;
    assign reg_s    = paddr[3:2];
    assign pready   = access_s;
    assign pslverr  = pslverr_s;
    assign prdata   = prdata_s;
    assign tx       = tx_q;
    assign unused_s = ^{paddr[31:4], paddr[1:0], pwdata[31:16], tx_count_s, rx_count_s};

    assign status_s = {(tx_state_q != TX_IDLE), par_q, frm_q, ovr_q,
                       rx_full_s, rx_empty_s, tx_full_s, tx_empty_s};

    // APB decode: side-effect strobes, error response and read mux.
    always_comb begin
        pslverr_s   = 1'b0;
        tx_push_s   = 1'b0;
        rx_pop_s    = 1'b0;
        status_rd_s = 1'b0;
        ctrl_wr_s   = 1'b0;
        div_wr_s    = 1'b0;
        prdata_s    = 32'd0;
        if (access_s) begin
            case (reg_s)
                REG_DATA: begin
                    if (pwrite) begin
                        if (tx_full_s) pslverr_s = 1'b1;
                        else           tx_push_s = 1'b1;
                    end else if (rx_empty_s) begin
                        pslverr_s = 1'b1;
                    end else begin
                        rx_pop_s = 1'b1;
                        prdata_s = {{(32-DATA_BITS){1'b0}}, rx_rdata_s};
                    end
                end
                REG_STATUS: begin
                    if (pwrite) begin
                        pslverr_s = 1'b1;
                    end else begin
                        status_rd_s = 1'b1;
                        prdata_s    = {24'd0, status_s};
                    end
                end
                REG_CTRL: begin
                    if (pwrite) ctrl_wr_s = 1'b1;
                    else        prdata_s  = {29'd0, ctrl_q};
                end
                REG_DIV: begin
                    if (pwrite) div_wr_s = 1'b1;
                    else        prdata_s = {16'd0, div_q};
                end
                default: pslverr_s = 1'b0;
            endcase
        end else begin
            pslverr_s = 1'b0;
        end
    end

    // Zero-extended characters for the parity helper.
    always_comb begin
        tx_wide_s = 8'd0;
        rx_wide_s = 8'd0;
        tx_wide_s[DATA_BITS-1:0] = tx_rdata_s;
        rx_wide_s[DATA_BITS-1:0] = rx_data_q;
    end

    // Control registers and sticky error flags; a same-cycle event beats the read-clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q <= 3'd0;
            div_q  <= DIV_RESET;
            ovr_q  <= 1'b0;
            frm_q  <= 1'b0;
            par_q  <= 1'b0;
        end else begin
            if (ctrl_wr_s) ctrl_q <= pwdata[2:0];
            if (div_wr_s)  div_q  <= (pwdata[15:0] < 16'd2) ? 16'd2 : pwdata[15:0];
            ovr_q <= (ovr_q & ~status_rd_s) | ovr_evt_s;
            frm_q <= (frm_q & ~status_rd_s) | frm_evt_s;
            par_q <= (par_q & ~status_rd_s) | par_evt_s;
        end
    end

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push_i(tx_push_s), .pop_i(tx_pop_s),
        .wdata_i(pwdata[DATA_BITS-1:0]), .rdata_o(tx_rdata_s),
        .full_o(tx_full_s), .empty_o(tx_empty_s), .count_o(tx_count_s)
    );

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push_i(rx_push_s), .pop_i(rx_pop_s),
        .wdata_i(rx_data_q), .rdata_o(rx_rdata_s),
        .full_o(rx_full_s), .empty_o(rx_empty_s), .count_o(rx_count_s)
    );

    // A new frame is fetched from IDLE or at the end of a stop bit (back-to-back).
    assign tx_pop_s = ctrl_q[CTRL_ENABLE] & ~tx_empty_s &
                      ((tx_state_q == TX_IDLE) | ((tx_state_q == TX_STOP) & (tx_cnt_q == 16'd0)));

    // TX FSM; the bit counter reloads from div_q at every bit boundary.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_idx_q   <= 3'd0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    tx_q <= 1'b1;
                    if (tx_pop_s) begin
                        tx_state_q <= TX_START;
                        tx_cnt_q   <= div_q - 16'd1;
                        tx_shift_q <= tx_rdata_s;
                        tx_par_q   <= calc_parity(tx_wide_s, ctrl_q[CTRL_PAR_ODD]);
                        tx_q       <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == 16'd0) begin
                        tx_state_q <= TX_DATA;
                        tx_cnt_q   <= div_q - 16'd1;
                        tx_idx_q   <= 3'd0;
                        tx_q       <= tx_shift_q[0];
                    end else tx_cnt_q <= tx_cnt_q - 16'd1;
                end
                TX_DATA: begin
                    if (tx_cnt_q == 16'd0) begin
                        tx_cnt_q <= div_q - 16'd1;
                        if (tx_idx_q == LAST_BIT) begin
                            tx_state_q <= ctrl_q[CTRL_PAR_EN] ? TX_PARITY : TX_STOP;
                            tx_q       <= ctrl_q[CTRL_PAR_EN] ? tx_par_q : 1'b1;
                        end else begin
                            tx_idx_q   <= tx_idx_q + 3'd1;
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_q       <= tx_shift_q[1];
                        end
                    end else tx_cnt_q <= tx_cnt_q - 16'd1;
                end
                TX_PARITY: begin
                    if (tx_cnt_q == 16'd0) begin
                        tx_state_q <= TX_STOP;
                        tx_cnt_q   <= div_q - 16'd1;
                        tx_q       <= 1'b1;
                    end else tx_cnt_q <= tx_cnt_q - 16'd1;
                end
                TX_STOP: begin
                    if (tx_cnt_q != 16'd0) begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end else if (tx_pop_s) begin
                        tx_state_q <= TX_START;
                        tx_cnt_q   <= div_q - 16'd1;
                        tx_shift_q <= tx_rdata_s;
                        tx_par_q   <= calc_parity(tx_wide_s, ctrl_q[CTRL_PAR_ODD]);
                        tx_q       <= 1'b0;
                    end else begin
                        tx_state_q <= TX_IDLE;
                        tx_q       <= 1'b1;
                    end
                end
                default: begin
                    tx_state_q <= TX_IDLE;
                    tx_q       <= 1'b1;
                end
            endcase
        end
    end

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    assign rx_stop_smp_s = (rx_state_q == RX_STOP) & (rx_cnt_q == 16'd0);
    assign par_bad_s     = ctrl_q[CTRL_PAR_EN] & (rx_par_q != calc_parity(rx_wide_s, ctrl_q[CTRL_PAR_ODD]));
    assign frm_evt_s     = rx_stop_smp_s & ~rx_s2_q;
    assign par_evt_s     = rx_stop_smp_s & rx_s2_q & par_bad_s;
    assign rx_push_s     = rx_stop_smp_s & rx_s2_q & ~par_bad_s;
    assign ovr_evt_s     = rx_push_s & rx_full_s & ~rx_pop_s;

    // RX FSM: sample mid-bit, DIV cycles apart after the half-bit start check.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_idx_q   <= 3'd0;
            rx_data_q  <= '0;
            rx_par_q   <= 1'b0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q & ~rx_s2_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= {1'b0, div_q[15:1]} - 16'd1;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q != 16'd0) begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end else if (rx_s2_q) begin
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_state_q <= RX_DATA;
                        rx_cnt_q   <= div_q - 16'd1;
                        rx_idx_q   <= 3'd0;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == 16'd0) begin
                        rx_cnt_q  <= div_q - 16'd1;
                        rx_data_q <= {rx_s2_q, rx_data_q[DATA_BITS-1:1]};
                        rx_idx_q  <= rx_idx_q + 3'd1;
                        if (rx_idx_q == LAST_BIT) begin
                            rx_state_q <= ctrl_q[CTRL_PAR_EN] ? RX_PARITY : RX_STOP;
                        end
                    end else rx_cnt_q <= rx_cnt_q - 16'd1;
                end
                RX_PARITY: begin
                    if (rx_cnt_q == 16'd0) begin
                        rx_par_q   <= rx_s2_q;
                        rx_state_q <= RX_STOP;
                        rx_cnt_q   <= div_q - 16'd1;
                    end else rx_cnt_q <= rx_cnt_q - 16'd1;
                end
                RX_STOP: begin
                    if (rx_cnt_q == 16'd0) rx_state_q <= RX_IDLE;
                    else                   rx_cnt_q   <= rx_cnt_q - 16'd1;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_core.sv
// Directed scoreboard bench for apb_uart_core: APB register access plus serial TX/RX framing.
module tb_apb_uart_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] paddr = 32'd0;
    logic [31:0] pwdata = 32'd0;
    logic        pwrite = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        rx = 1'b1;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        tx;

    int errors = 0;
    int checks = 0;
    logic [7:0] rx_exp_q[$];
    logic [7:0] tx_exp_q[$];

    always #5 clk = ~clk;

    apb_uart_core #(.DATA_BITS(8), .FIFO_DEPTH(8), .DIV_RESET(16'd16)) dut (
        .clk(clk), .rst(rst), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel), .penable(penable), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .rx(rx), .tx(tx)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        @(posedge clk); #1;
        penable = 1'b1;
        #2;
        err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        @(posedge clk); #1;
        penable = 1'b1;
        #2;
        data = prdata;
        err  = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    function automatic logic [39:0] exp_frame(input logic [7:0] d);
        logic [39:0] v;
        for (int k = 0; k < 40; k++) begin
            if (k < 4)       v[k] = 1'b0;
            else if (k < 36) v[k] = d[(k-4)/4];
            else             v[k] = 1'b1;
        end
        return v;
    endfunction

    // One 8N1 frame at DIV=4, sampled every cycle; optionally waits (bounded) for the start bit.
    task automatic capture_frame(input bit wait_start, output logic [39:0] obs, output bit ok);
        int n;
        ok  = 1'b1;
        obs = 40'd0;
        @(negedge clk);
        if (wait_start) begin
            n = 0;
            while (tx !== 1'b0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (tx !== 1'b0) ok = 1'b0;
        end
        obs[0] = tx;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            obs[k] = tx;
        end
    endtask

    task automatic drive_rx_frame(input logic [7:0] d, input logic par_en, input logic par_bit);
        rx = 1'b0;
        wait_cyc(4);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_cyc(4);
        end
        if (par_en) begin
            rx = par_bit;
            wait_cyc(4);
        end
        rx = 1'b1;
        wait_cyc(6);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic e;
        rst = 1'b0; psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h4;
        wait_cyc(3);
        checks++; if (pready !== 1'b0) begin errors++; $display("FAIL reset_pready: got %b want 0", pready); end
        checks++; if (prdata !== 32'd0) begin errors++; $display("FAIL reset_prdata: got %h want 0", prdata); end
        checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr: got %b want 0", pslverr); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        psel = 1'b0; penable = 1'b0;
        wait_cyc(1);
        rst = 1'b1;
        wait_cyc(1);
        apb_read(32'h4, d, e);
        checks++; if (d !== 32'h05) begin errors++; $display("FAIL reset_status: got %h want 05", d); end
        apb_read(32'hC, d, e);
        checks++; if (d !== 32'd16) begin errors++; $display("FAIL reset_div: got %0d want 16", d); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL release_tx: got %b want 1", tx); end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        logic e;
        apb_write(32'hC, 32'd1, e);
        apb_read(32'hC, d, e);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL div_clamp: got %0d want 2", d); end
        apb_write(32'h4, 32'hFF, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL status_write_err: got %b want 1", e); end
        apb_read(32'h4, d, e);
        checks++; if (d !== 32'h05) begin errors++; $display("FAIL status_after_write: got %h want 05", d); end
    endtask

    task automatic test_tx_frame();
        logic [31:0] d;
        logic e;
        logic [39:0] obs;
        bit ok;
        logic [7:0] exp;
        apb_write(32'hC, 32'd4, e);
        apb_write(32'h8, 32'h1, e);
        apb_write(32'h0, 32'h55, e);
        tx_exp_q.push_back(8'h55);
        fork
            capture_frame(1'b1, obs, ok);
            begin
                for (int i = 0; i < 3; i++) begin
                    logic [31:0] s;
                    logic se;
                    wait_cyc(2);
                    apb_read(32'h4, s, se);
                    checks++; if (s[7] !== 1'b1) begin errors++; $display("FAIL tx_busy_%0d: got %b want 1", i, s[7]); end
                    wait_cyc(3);
                end
            end
        join
        exp = tx_exp_q.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL tx_start_timeout: got no start bit want start within 20 cycles"); end
        checks++; if (obs !== exp_frame(exp)) begin errors++; $display("FAIL tx_frame_55: got %h want %h", obs, exp_frame(exp)); end
        wait_cyc(2);
        apb_read(32'h4, d, e);
        checks++; if (d !== 32'h05) begin errors++; $display("FAIL tx_idle_status: got %h want 05", d); end
    endtask

    task automatic test_rx_parity();
        logic [31:0] d;
        logic e;
        apb_write(32'h8, 32'h7, e);
        rx_exp_q.push_back(8'hA3);
        drive_rx_frame(8'hA3, 1'b1, 1'b1);
        wait_cyc(4);
        apb_read(32'h0, d, e);
        checks++; if (d !== {24'd0, rx_exp_q.pop_front()}) begin errors++; $display("FAIL rx_parity_data: got %h want a3", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL rx_parity_err: got %b want 0", e); end
        apb_read(32'h4, d, e);
        checks++; if (d !== 32'h05) begin errors++; $display("FAIL rx_parity_status: got %h want 05", d); end
        drive_rx_frame(8'hA3, 1'b1, 1'b0);
        wait_cyc(4);
        apb_read(32'h4, d, e);
        checks++; if (d !== 32'h45) begin errors++; $display("FAIL bad_parity_status: got %h want 45", d); end
        apb_read(32'h0, d, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL bad_parity_empty_read: got %b want 1", e); end
        apb_read(32'h4, d, e);
        checks++; if (d !== 32'h05) begin errors++; $display("FAIL bad_parity_cleared: got %h want 05", d); end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] d;
        logic e;
        logic [7:0] c;
        apb_write(32'h8, 32'h0, e);
        for (int i = 0; i < 9; i++) begin
            c = 8'(i * 37 + 5);
            if (i < 8) rx_exp_q.push_back(c);
            drive_rx_frame(c, 1'b0, 1'b0);
        end
        wait_cyc(4);
        apb_read(32'h4, d, e);
        checks++; if (d !== 32'h19) begin errors++; $display("FAIL overrun_status: got %h want 19", d); end
        for (int i = 0; i < 8; i++) begin
            apb_read(32'h0, d, e);
            c = rx_exp_q.pop_front();
            checks++; if (d !== {24'd0, c} || e !== 1'b0) begin errors++; $display("FAIL overrun_data_%0d: got %h err %b want %h err 0", i, d, e, c); end
        end
        apb_read(32'h4, d, e);
        checks++; if (d !== 32'h05) begin errors++; $display("FAIL overrun_drained: got %h want 05", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic e;
        logic [39:0] obs;
        bit ok;
        logic [7:0] c;
        apb_write(32'h8, 32'h0, e);
        for (int i = 0; i < 8; i++) begin
            c = 8'(i * 29 + 7);
            apb_write(32'h0, {24'd0, c}, e);
            tx_exp_q.push_back(c);
            checks++; if (e !== 1'b0) begin errors++; $display("FAIL fill_err_%0d: got %b want 0", i, e); end
        end
        apb_write(32'h0, 32'hEE, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL full_write_err: got %b want 1", e); end
        apb_read(32'h4, d, e);
        checks++; if (d !== 32'h06) begin errors++; $display("FAIL full_status: got %h want 06", d); end
        apb_write(32'h8, 32'h1, e);
        for (int f = 0; f < 8; f++) begin
            capture_frame(f == 0, obs, ok);
            c = tx_exp_q.pop_front();
            checks++; if (!ok || obs !== exp_frame(c)) begin errors++; $display("FAIL b2b_frame_%0d: got %h ok %b want %h", f, obs, ok, exp_frame(c)); end
        end
        wait_cyc(10);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL b2b_idle_tx: got %b want 1", tx); end
        apb_read(32'h4, d, e);
        checks++; if (d !== 32'h05) begin errors++; $display("FAIL b2b_status: got %h want 05", d); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        logic e;
        apb_write(32'h0, 32'h00, e);
        wait_cyc(8);
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midframe_tx_low: got %b want 0", tx); end
        rst = 1'b0;
        wait_cyc(1);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midframe_abort: got %b want 1", tx); end
        rst = 1'b1;
        wait_cyc(2);
        apb_read(32'h8, d, e);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL midframe_ctrl: got %h want 0", d); end
        apb_read(32'h4, d, e);
        checks++; if (d !== 32'h05) begin errors++; $display("FAIL midframe_status: got %h want 05", d); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_tx_frame();
        test_rx_parity();
        test_rx_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
